// File: rtl/mac_tx_stream.sv
// Ethernet transmit MAC: byte stream in, preamble/header/payload/pad/FCS out on an RMII or MII pin
// group, followed by the inter-frame gap. Define MAC_TX_VLAN_EN to insert an 802.1Q tag.
module mac_tx_stream #(
  parameter logic [47:0] MAC         = 48'h0,
  parameter int unsigned DW          = 2,
  parameter int unsigned IFG_BYTES   = 12,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [47:0]   i_dst_mac,
  input  logic [15:0]   i_etype,
  input  logic [15:0]   i_vlan,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  input  logic          i_last,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_err,
  output logic [DW-1:0] o_txd,
  output logic          o_txen
);

  if (!(DW == 2 || DW == 4) || IFG_BYTES < 1 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 2047)
  begin : g_param_check
    $error("mac_tx_stream: illegal parameter (DW must be 2 or 4)");
  end

`ifdef MAC_TX_VLAN_EN
  localparam int unsigned HDR_BYTES = 18;
  localparam int unsigned MIN_DATA  = 42;
`else
  localparam int unsigned HDR_BYTES = 14;
  localparam int unsigned MIN_DATA  = 46;
`endif
  localparam int unsigned HB        = HDR_BYTES * 8;
  localparam logic [1:0]  SLOT_LAST = 2'(8 / DW - 1);
  // The IDLE cycle before the next PRE supplies the final symbol time of the gap.
  localparam int unsigned GAP_CYC   = IFG_BYTES * (8 / DW) - 1;

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StPay, StPad, StFcs, StIfg} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [HB-1:0]   hdr_q, hdr_d, hdr_vec;
  logic [31:0]     crc_q, crc_d, fcs_word;
  logic [10:0]     len_q, len_d;
  logic [15:0]     gap_q, gap_d;
  logic            end_q, end_d, bad_q, bad_d, err_q, err_d;
  logic [DW-1:0]   txd_q, txd_d;
  logic            txen_q, txen_d;
  logic            active, slot_end, take, close;

`ifdef MAC_TX_VLAN_EN
  assign hdr_vec = {i_dst_mac, MAC, 16'h8100, i_vlan, i_etype};
`else
  logic unused_vlan;
  assign unused_vlan = ^i_vlan;
  assign hdr_vec = {i_dst_mac, MAC, i_etype};
`endif

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign active   = state_q inside {StPre, StHdr, StPay, StPad, StFcs};
  assign slot_end = cnt_q == SLOT_LAST;
  assign o_busy   = state_q != StIdle;
  assign o_err    = err_q;
  assign o_txd    = txd_q;
  assign o_txen   = txen_q;
  assign txen_d   = active;
  assign txd_d    = active ? sh_q[DW-1:0] : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    hdr_d    = hdr_q;
    crc_d    = crc_q;
    len_d    = len_q;
    gap_d    = gap_q;
    end_d    = end_q;
    bad_d    = bad_q;
    err_d    = 1'b0;
    o_ready  = 1'b0;
    take     = 1'b0;
    close    = 1'b0;
    fcs_word = '0;

    if (active) begin
      cnt_d = slot_end ? 2'd0 : cnt_q + 2'd1;
      sh_d  = sh_q >> DW;
    end

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d = StPre;
          hdr_d   = hdr_vec;
          sh_d    = 8'h55;
          cnt_d   = '0;
          idx_d   = '0;
          crc_d   = 32'hFFFFFFFF;
          len_d   = '0;
          end_d   = 1'b0;
          bad_d   = 1'b0;
        end
      end
      StPre: begin
        if (slot_end) begin
          if (idx_q == 5'd7) begin
            sh_d    = hdr_q[HB-1 -: 8];
            hdr_d   = hdr_q << 8;
            crc_d   = crc_byte(crc_q, hdr_q[HB-1 -: 8]);
            idx_d   = '0;
            state_d = StHdr;
          end else begin
            sh_d  = (idx_q == 5'd6) ? 8'hD5 : 8'h55;
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StHdr: begin
        if (slot_end) begin
          if (idx_q == 5'(HDR_BYTES - 1)) begin
            take = 1'b1;
          end else begin
            sh_d  = hdr_q[HB-1 -: 8];
            hdr_d = hdr_q << 8;
            crc_d = crc_byte(crc_q, hdr_q[HB-1 -: 8]);
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StPay: begin
        if (slot_end) begin
          if (end_q) close = 1'b1;
          else       take  = 1'b1;
        end
      end
      StPad: begin
        if (slot_end) close = 1'b1;
      end
      StFcs: begin
        // crc_q holds the remaining FCS bytes here, shifted out low byte first.
        if (slot_end) begin
          if (idx_q == 5'd3) begin
            state_d = StIfg;
            gap_d   = '0;
          end else begin
            sh_d  = crc_q[7:0];
            crc_d = crc_q >> 8;
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StIfg: begin
        if (gap_q == 16'(GAP_CYC - 1)) state_d = StIdle;
        else                           gap_d   = gap_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      o_ready = 1'b1;
      if (i_valid) begin
        sh_d    = i_data;
        crc_d   = crc_byte(crc_q, i_data);
        len_d   = len_q + 11'd1;
        state_d = StPay;
        if (i_last) begin
          end_d = 1'b1;
        end else if (len_q + 11'd1 == 11'(MAX_PAYLOAD)) begin
          end_d = 1'b1;
          err_d = 1'b1;
        end
      end else begin
        // Underrun: close the frame with a deliberately wrong FCS.
        err_d = 1'b1;
        bad_d = 1'b1;
        close = 1'b1;
      end
    end

    if (close) begin
      if (len_q < 11'(MIN_DATA)) begin
        sh_d    = 8'h00;
        crc_d   = crc_byte(crc_q, 8'h00);
        len_d   = len_q + 11'd1;
        state_d = StPad;
      end else begin
        fcs_word = bad_d ? crc_q : ~crc_q;
        sh_d     = fcs_word[7:0];
        crc_d    = {8'h00, fcs_word[31:8]};
        idx_d    = '0;
        state_d  = StFcs;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      hdr_q   <= '0;
      crc_q   <= 32'hFFFFFFFF;
      len_q   <= '0;
      gap_q   <= '0;
      end_q   <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      txd_q   <= '0;
      txen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      hdr_q   <= hdr_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      end_q   <= end_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_stream.sv
// Directed bench for mac_tx_stream: one DW=2 and one DW=4 instance sharing stimulus; the idle one
// is held in reset. Expected frames come from a byte-level model built in the bench.
module tb_mac_tx_stream;

  localparam logic [47:0] SRC = 48'h021122334455;
`ifdef MAC_TX_VLAN_EN
  localparam int MIN_DATA = 42;
`else
  localparam int MIN_DATA = 46;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2 = 1'b1, rst4 = 1'b1, sel4 = 1'b0;
  logic [47:0] dst   = 48'hA0B1C2D3E4F5;
  logic [15:0] etype = 16'h0800;
  logic [15:0] vlan  = 16'h0123;
  logic        valid = 1'b0, last = 1'b0;
  logic [7:0]  data  = 8'h00;

  logic       rdy2, busy2, err2, txen2, rdy4, busy4, err4, txen4;
  logic [1:0] txd2;
  logic [3:0] txd4;

  mac_tx_stream #(.MAC(SRC), .DW(2), .IFG_BYTES(12), .MAX_PAYLOAD(64)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_dst_mac(dst), .i_etype(etype), .i_vlan(vlan),
    .i_valid(valid), .i_data(data), .i_last(last), .o_ready(rdy2), .o_busy(busy2),
    .o_err(err2), .o_txd(txd2), .o_txen(txen2)
  );

  mac_tx_stream #(.MAC(SRC), .DW(4), .IFG_BYTES(12), .MAX_PAYLOAD(64)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_dst_mac(dst), .i_etype(etype), .i_vlan(vlan),
    .i_valid(valid), .i_data(data), .i_last(last), .o_ready(rdy4), .o_busy(busy4),
    .o_err(err4), .o_txd(txd4), .o_txen(txen4)
  );

  wire       rdy  = sel4 ? rdy4 : rdy2;
  wire       busy = sel4 ? busy4 : busy2;
  wire       err  = sel4 ? err4 : err2;
  wire       txen = sel4 ? txen4 : txen2;
  wire [3:0] txd  = sel4 ? txd4 : {2'b00, txd2};

  int checks = 0, errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 8'hAB);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      logic fb;
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Wire monitor: deserialises symbols, records completed frames, gaps and error pulses.
  logic [7:0] rx[$], fr_last[$], fr_prev[$], exp_q[$], got_q[$];
  int  err_at[$];
  int  frames = 0, cyc = 0, cyc_last = 0, cyc_prev = 0, gap_cnt = 0, gap_last = 0;
  int  bitpos = 0, acc_cnt = 0;
  logic [7:0] sacc = 8'h00;
  logic prev_txen = 1'b0;

  always @(negedge clk) begin
    int dw;
    dw = sel4 ? 4 : 2;
    if (valid && rdy) acc_cnt++;
    if (err) err_at.push_back(acc_cnt);
    if (txen) begin
      if (!prev_txen) gap_last = gap_cnt;
      cyc++;
      sacc = sacc | (8'(txd) << bitpos);
      bitpos += dw;
      if (bitpos >= 8) begin
        rx.push_back(sacc);
        sacc   = 8'h00;
        bitpos = 0;
      end
    end else begin
      if (prev_txen) begin
        fr_prev  = fr_last;
        fr_last  = rx;
        rx.delete();
        cyc_prev = cyc_last;
        cyc_last = cyc;
        cyc      = 0;
        bitpos   = 0;
        sacc     = 8'h00;
        gap_cnt  = 0;
        frames++;
      end
      gap_cnt++;
    end
    prev_txen = txen;
  end

  task automatic build_exp(input int first, input int n, input bit bad);
    logic [47:0] s;
    logic [31:0] c;
    s = SRC;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 5; k >= 0; k--) exp_q.push_back(dst[8*k +: 8]);
    for (int k = 5; k >= 0; k--) exp_q.push_back(s[8*k +: 8]);
`ifdef MAC_TX_VLAN_EN
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    exp_q.push_back(vlan[15:8]);
    exp_q.push_back(vlan[7:0]);
`endif
    exp_q.push_back(etype[15:8]);
    exp_q.push_back(etype[7:0]);
    for (int i = 0; i < n; i++) exp_q.push_back(pat(first + i));
    for (int p = n; p < MIN_DATA; p++) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
    if (!bad) c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic compare_frame(input string tag, input bit bad, input int obs_cyc, input int slot);
    int n, ne, mis;
    logic [31:0] gw, ew, r;
    n   = got_q.size();
    ne  = exp_q.size();
    mis = 0;
    check_val({tag, " length"}, n, ne);
    for (int i = 0; i < ne; i++) if (i >= n || got_q[i] !== exp_q[i]) mis++;
    check_val({tag, " byte mismatches"}, mis, 0);
    gw = (n >= 4) ? {got_q[n-1], got_q[n-2], got_q[n-3], got_q[n-4]} : 32'h0;
    ew = {exp_q[ne-1], exp_q[ne-2], exp_q[ne-3], exp_q[ne-4]};
    check_val({tag, " fcs"}, gw, ew);
    if (!bad) begin
      r = 32'hFFFFFFFF;
      for (int i = 8; i < n; i++) r = crc_upd(r, got_q[i]);
      check_val({tag, " crc residue"}, r, 32'hDEBB20E3);
    end
    check_val({tag, " txen cycles"}, obs_cyc, ne * slot);
  endtask

  task automatic drive(input int first, input int n, input bit with_last, input int drop_at);
    for (int i = 0; i < n; i++) begin
      int t;
      if (drop_at != 0 && i + 1 == drop_at) begin
        valid = 1'b0;
        last  = 1'b0;
        return;
      end
      valid = 1'b1;
      data  = pat(first + i);
      last  = with_last && (i == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!rdy && t < 3000);
      if (!rdy) begin
        check_val("ready timeout", {31'b0, rdy}, 32'd1);
        valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames < target && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check_val("frame count", frames, target);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 300);
    check_val("return to idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int f0, eb, ab;
    repeat (3) @(negedge clk);
    check_val("reset txen", {31'b0, txen}, 0);
    rst2 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset txd", {28'b0, txd}, 0);
    check_val("reset txen idle", {31'b0, txen}, 0);
    check_val("reset ready", {31'b0, rdy}, 0);
    check_val("reset busy", {31'b0, busy}, 0);
    check_val("reset err", {31'b0, err}, 0);

    // 46-byte payload on RMII, with start-up latency
    f0 = frames;
    eb = err_at.size();
    @(posedge clk);
    #1;
    valid = 1'b1;
    data  = pat(1);
    @(negedge clk);
    check_val("busy before exit", {31'b0, busy}, 0);
    @(negedge clk);
    check_val("busy after exit", {31'b0, busy}, 1);
    check_val("txen one cycle", {31'b0, txen}, 0);
    @(negedge clk);
    check_val("txen two cycles", {31'b0, txen}, 1);
    check_val("first symbol", {28'b0, txd}, 32'h1);
    drive(1, 46, 1'b1, 0);
    valid = 1'b0;
    last  = 1'b0;
    wait_frames(f0 + 1);
    build_exp(1, 46, 1'b0);
    got_q = fr_last;
    compare_frame("pay46", 1'b0, cyc_last, 4);
    wait_idle();

    // single byte 0xAB, padded to the minimum
    f0 = frames;
    drive(0, 1, 1'b1, 0);
    valid = 1'b0;
    last  = 1'b0;
    wait_frames(f0 + 1);
    build_exp(0, 1, 1'b0);
    got_q = fr_last;
    compare_frame("pay1", 1'b0, cyc_last, 4);
    check_val("pay1 txen 288", cyc_last, 288);
`ifdef MAC_TX_VLAN_EN
    check_val("vlan tag", {got_q[20], got_q[21], got_q[22], got_q[23]}, 32'h81000123);
`endif
    check_val("no err so far", err_at.size() - eb, 0);
    wait_idle();

    // underrun at payload byte 10
    f0 = frames;
    eb = err_at.size();
    drive(1, 20, 1'b0, 10);
    wait_frames(f0 + 1);
    build_exp(1, 9, 1'b1);
    got_q = fr_last;
    compare_frame("underrun", 1'b1, cyc_last, 4);
    check_val("underrun err pulses", err_at.size() - eb, 1);
    wait_idle();

    // oversize: 100 bytes without a last flag
    f0 = frames;
    eb = err_at.size();
    ab = acc_cnt;
    drive(1, 100, 1'b0, 0);
    valid = 1'b0;
    wait_frames(f0 + 2);
    check_val("oversize err byte", err_at[eb] - ab, 64);
    check_val("oversize err pulses", err_at.size() - eb, 2);
    build_exp(1, 64, 1'b0);
    got_q = fr_prev;
    compare_frame("oversize f1", 1'b0, cyc_prev, 4);
    build_exp(65, 36, 1'b1);
    got_q = fr_last;
    compare_frame("oversize f2", 1'b1, cyc_last, 4);
    wait_idle();

    // switch to the MII instance: back-to-back 60-byte frames
    rst2 = 1'b1;
    sel4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    f0 = frames;
    drive(1, 60, 1'b1, 0);
    drive(61, 60, 1'b1, 0);
    valid = 1'b0;
    last  = 1'b0;
    wait_frames(f0 + 2);
    check_val("b2b gap", gap_last, 24);
    build_exp(1, 60, 1'b0);
    got_q = fr_prev;
    compare_frame("b2b f1", 1'b0, cyc_prev, 2);
    build_exp(61, 60, 1'b0);
    got_q = fr_last;
    compare_frame("b2b f2", 1'b0, cyc_last, 2);
    wait_idle();

    // asynchronous reset mid-payload
    valid = 1'b1;
    data  = 8'h3C;
    last  = 1'b0;
    repeat (60) @(negedge clk);
    check_val("txen before reset", {31'b0, txen}, 1);
    rst4 = 1'b1;
    #1;
    check_val("txen async drop", {31'b0, txen}, 0);
    check_val("busy async drop", {31'b0, busy}, 0);
    valid = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    repeat (10) @(negedge clk);
    check_val("txen after reset", {31'b0, txen}, 0);
    check_val("busy after reset", {31'b0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
